// File: rtl/battleship_board_render.sv
// Two-stage pixel renderer for the player and PC Battleship boards with a blinking PC-board cursor.
// Optional macro BOARD_PC_REVEAL_EN shows PC board ships instead of concealing them as water.
module battleship_board_render #(
  parameter int unsigned N            = 5,
  parameter int unsigned CELL_W       = 54,
  parameter int unsigned CELL_H       = 70,
  parameter int unsigned ORG0_X       = 25,
  parameter int unsigned ORG1_X       = 345,
  parameter int unsigned ORG_Y        = 50,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [9:0]             x,
  input  logic [9:0]             y,
  input  logic                   frame_start,
  input  logic [2*N*N-1:0]       player_cells,
  input  logic [2*N*N-1:0]       pc_cells,
  input  logic [$clog2(N)-1:0]   cursor_row,
  input  logic [$clog2(N)-1:0]   cursor_col,
  input  logic                   cursor_valid,
  output logic [7:0]             r,
  output logic [7:0]             g,
  output logic [7:0]             b
);

  localparam int unsigned IW    = $clog2(N);
  localparam int unsigned BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned BRD_W = N * CELL_W;
  localparam int unsigned BRD_H = N * CELL_H;

  localparam logic [23:0] C_BLACK  = 24'h000000;
  localparam logic [23:0] C_WHITE  = 24'hFFFFFF;
  localparam logic [23:0] C_CURSOR = 24'hFFFF00;
  localparam logic [23:0] C_HIT    = 24'hFF0000;
  localparam logic [23:0] C_MISS   = 24'h808080;
  localparam logic [23:0] C_SHIP   = 24'h00A000;
  localparam logic [23:0] C_WATER  = 24'h000060;

  typedef enum logic [1:0] {
    BSEL_NONE   = 2'd0,
    BSEL_PLAYER = 2'd1,
    BSEL_PC     = 2'd2
  } bsel_e;

  bsel_e         sel_d, sel_q;
  logic          line_d, line_q;
  logic [IW-1:0] row_d, row_q;
  logic [IW-1:0] col_d, col_q;
  logic [23:0]   rgb_d, rgb_q;
  logic [BW-1:0] cnt_d, cnt_q;
  logic          phase_d, phase_q;

  logic [31:0]   xw, yw, off_x, off_y;
  logic          in_y, in_b0, in_b1;
  logic [31:0]   cell_idx;
  logic [1:0]    p_code, c_code;
  logic          cur_hit;

  // Stage 1: board hit test, grid-line detect and cell index via comparison chain
  always_comb begin
    xw     = 32'(x);
    yw     = 32'(y);
    in_y   = (yw >= ORG_Y) && (yw <= ORG_Y + BRD_H);
    in_b0  = in_y && (xw >= ORG0_X) && (xw <= ORG0_X + BRD_W);
    in_b1  = in_y && (xw >= ORG1_X) && (xw <= ORG1_X + BRD_W);
    off_x  = xw - ((in_b1 && !in_b0) ? ORG1_X : ORG0_X);
    off_y  = yw - ORG_Y;
    sel_d  = BSEL_NONE;
    line_d = 1'b0;
    row_d  = '0;
    col_d  = '0;
    if (in_b0) begin
      sel_d = BSEL_PLAYER;
    end else if (in_b1) begin
      sel_d = BSEL_PC;
    end
    for (int unsigned i = 0; i <= N; i++) begin
      if (off_x == i * CELL_W || off_y == i * CELL_H) begin
        line_d = 1'b1;
      end
    end
    for (int unsigned i = 1; i < N; i++) begin
      if (off_x >= i * CELL_W) begin
        col_d = IW'(i);
      end
      if (off_y >= i * CELL_H) begin
        row_d = IW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q  <= BSEL_NONE;
      line_q <= 1'b0;
      row_q  <= '0;
      col_q  <= '0;
    end else begin
      sel_q  <= sel_d;
      line_q <= line_d;
      row_q  <= row_d;
      col_q  <= col_d;
    end
  end

  // Stage 2: decode live cell arrays and cursor into a colour
  always_comb begin
    cell_idx = 32'(row_q) * N + 32'(col_q);
    p_code   = 2'(player_cells >> (cell_idx * 2));
    c_code   = 2'(pc_cells >> (cell_idx * 2));
    cur_hit  = (sel_q == BSEL_PC) && cursor_valid && phase_q &&
               (cursor_row == row_q) && (cursor_col == col_q);
    rgb_d    = C_BLACK;
    if (sel_q == BSEL_NONE) begin
      rgb_d = C_BLACK;
    end else if (line_q) begin
      rgb_d = C_WHITE;
    end else if (cur_hit) begin
      rgb_d = C_CURSOR;
    end else if (sel_q == BSEL_PLAYER) begin
      case (p_code)
        2'd1:    rgb_d = C_SHIP;
        2'd2:    rgb_d = C_HIT;
        2'd3:    rgb_d = C_MISS;
        default: rgb_d = C_WATER;
      endcase
    end else begin
      case (c_code)
`ifdef BOARD_PC_REVEAL_EN
        2'd1:    rgb_d = C_SHIP;
`else
        2'd1:    rgb_d = C_WATER;
`endif
        2'd2:    rgb_d = C_HIT;
        2'd3:    rgb_d = C_MISS;
        default: rgb_d = C_WATER;
      endcase
    end
  end

  // Blink unit: phase flips each time the frame counter wraps
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (frame_start) begin
      if (cnt_q == BW'(BLINK_FRAMES - 1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q   <= C_BLACK;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign r = rgb_q[23:16];
  assign g = rgb_q[15:8];
  assign b = rgb_q[7:0];

endmodule

// File: tb/tb_battleship_board_render.sv
// Self-checking bench for battleship_board_render: directed scenarios plus a randomized pixel stream
// compared against a division/modulo based reference model.
module tb_battleship_board_render;

  localparam int N     = 5;
  localparam int CW    = 54;
  localparam int CH    = 70;
  localparam int ORG0  = 25;
  localparam int ORG1  = 345;
  localparam int ORGY  = 50;
  localparam int TB_BF = 2;
  localparam int CELLS = 2 * N * N;

  logic             clk;
  logic             rst;
  logic [9:0]       x;
  logic [9:0]       y;
  logic             frame_start;
  logic [CELLS-1:0] player_cells;
  logic [CELLS-1:0] pc_cells;
  logic [2:0]       cursor_row;
  logic [2:0]       cursor_col;
  logic             cursor_valid;
  logic [7:0]       r, g, b;
  logic [23:0]      rgb;

  int n_cmp;
  int n_bad;
  int pulses;

  assign rgb = {r, g, b};

  battleship_board_render #(
    .N(N), .CELL_W(CW), .CELL_H(CH), .ORG0_X(ORG0), .ORG1_X(ORG1),
    .ORG_Y(ORGY), .BLINK_FRAMES(TB_BF)
  ) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .frame_start(frame_start),
    .player_cells(player_cells), .pc_cells(pc_cells),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .cursor_valid(cursor_valid),
    .r(r), .g(g), .b(b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: colour of pixel (xx,yy) from the board rules, using plain division
  function automatic logic [23:0] model(input int xx, input int yy);
    int bd, org, col, row;
    logic [CELLS-1:0] cells;
    logic [1:0] code;
    bit ph;
    ph = ((pulses / TB_BF) % 2) == 1;
    bd = -1;
    if (yy >= ORGY && yy <= ORGY + N * CH) begin
      if (xx >= ORG0 && xx <= ORG0 + N * CW) bd = 0;
      else if (xx >= ORG1 && xx <= ORG1 + N * CW) bd = 1;
    end
    if (bd < 0) return 24'h000000;
    org = (bd == 1) ? ORG1 : ORG0;
    if ((xx - org) % CW == 0 || (yy - ORGY) % CH == 0) return 24'hFFFFFF;
    col = (xx - org) / CW;
    row = (yy - ORGY) / CH;
    if (bd == 1 && cursor_valid && ph && int'(cursor_row) == row && int'(cursor_col) == col)
      return 24'hFFFF00;
    cells = (bd == 1) ? pc_cells : player_cells;
    code  = 2'(cells >> (2 * (row * N + col)));
    case (code)
      2'd2: return 24'hFF0000;
      2'd3: return 24'h808080;
      2'd1: begin
        if (bd == 0) return 24'h00A000;
`ifdef BOARD_PC_REVEAL_EN
        return 24'h00A000;
`else
        return 24'h000060;
`endif
      end
      default: return 24'h000060;
    endcase
  endfunction

  task automatic settle(input int xx, input int yy);
    @(negedge clk);
    x = 10'(xx);
    y = 10'(yy);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    if (!rst) pulses++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    x = 10'd25;
    y = 10'd100;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        frame_start = 1'b1;
      end else begin
        frame_start = 1'b0;
      end
      @(negedge clk);
      n_cmp++;
      if (rgb !== 24'h000000) begin
        n_bad++;
        $display("FAIL reset_hold: got %06h expected 000000", rgb);
      end
    end
    frame_start = 1'b0;
    rst = 1'b0;
    pulses = 0;
    @(negedge clk);
    n_cmp++;
    if (rgb !== 24'h000000) begin
      n_bad++;
      $display("FAIL reset_first_clock: got %06h expected 000000", rgb);
    end
    @(negedge clk);
    n_cmp++;
    if (rgb !== 24'hFFFFFF) begin
      n_bad++;
      $display("FAIL reset_release_line: got %06h expected FFFFFF", rgb);
    end
  endtask

  task automatic test_player_cell();
    logic [23:0] want [3] = '{24'h00A000, 24'hFF0000, 24'h808080};
    for (int c = 1; c <= 3; c++) begin
      player_cells[1:0] = 2'(c);
      settle(30, 60);
      n_cmp++;
      if (rgb !== want[c-1] || rgb !== model(30, 60)) begin
        n_bad++;
        $display("FAIL player_cell_code%0d: got %06h expected %06h", c, rgb, want[c-1]);
      end
    end
  endtask

  task automatic test_conceal();
    logic [23:0] want;
`ifdef BOARD_PC_REVEAL_EN
    want = 24'h00A000;
`else
    want = 24'h000060;
`endif
    pc_cells[1:0] = 2'd1;
    settle(350, 60);
    n_cmp++;
    if (rgb !== want) begin
      n_bad++;
      $display("FAIL pc_ship_conceal: got %06h expected %06h", rgb, want);
    end
    pc_cells = '0;
  endtask

  task automatic test_blink();
    logic [23:0] want [3] = '{24'h000060, 24'hFFFF00, 24'h000060};
    pc_cells = '0;
    cursor_row = 3'd4;
    cursor_col = 3'd4;
    cursor_valid = 1'b1;
    for (int s = 0; s < 3; s++) begin
      if (s > 0) repeat (TB_BF) pulse_frame();
      settle(600, 390);
      n_cmp++;
      if (rgb !== want[s] || rgb !== model(600, 390)) begin
        n_bad++;
        $display("FAIL blink_step%0d: got %06h expected %06h", s, rgb, want[s]);
      end
    end
    repeat (TB_BF) pulse_frame();
    cursor_valid = 1'b0;
    settle(600, 390);
    n_cmp++;
    if (rgb !== 24'h000060) begin
      n_bad++;
      $display("FAIL blink_cursor_invalid: got %06h expected 000060", rgb);
    end
    cursor_valid = 1'b1;
    cursor_row = 3'd5;
    settle(600, 390);
    n_cmp++;
    if (rgb !== 24'h000060) begin
      n_bad++;
      $display("FAIL cursor_row_oob: got %06h expected 000060", rgb);
    end
    cursor_row = 3'd4;
  endtask

  task automatic test_boundaries();
    int bx [6] = '{10, 320, 615, 616, 295, 296};
    int by [6] = '{10, 200, 400, 400, 50, 50};
    logic [23:0] want [6] = '{24'h000000, 24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000};
    for (int i = 0; i < 6; i++) begin
      settle(bx[i], by[i]);
      n_cmp++;
      if (rgb !== want[i]) begin
        n_bad++;
        $display("FAIL boundary_%0d_%0d: got %06h expected %06h", bx[i], by[i], rgb, want[i]);
      end
    end
  endtask

  task automatic test_random_stream();
    logic [23:0] expq [$];
    logic [23:0] exp_v;
    int xx, yy;
    for (int rnd = 0; rnd < 6; rnd++) begin
      if (rnd % 2 == 1) repeat (TB_BF) pulse_frame();
      player_cells = CELLS'({$urandom(), $urandom()});
      pc_cells     = CELLS'({$urandom(), $urandom()});
      cursor_row   = 3'($urandom_range(0, 5));
      cursor_col   = 3'($urandom_range(0, 5));
      cursor_valid = ($urandom_range(0, 3) != 0);
      expq.delete();
      for (int i = 0; i < 302; i++) begin
        @(negedge clk);
        if (i >= 2) begin
          exp_v = expq.pop_front();
          n_cmp++;
          if (rgb !== exp_v) begin
            n_bad++;
            $display("FAIL stream_r%0d_p%0d: got %06h expected %06h", rnd, i - 2, rgb, exp_v);
          end
        end
        if (i < 300) begin
          if ($urandom_range(0, 3) == 0)
            xx = (($urandom_range(0, 1) == 1) ? ORG1 : ORG0) + CW * int'($urandom_range(0, 5));
          else
            xx = int'($urandom_range(0, 639));
          if ($urandom_range(0, 3) == 0)
            yy = ORGY + CH * int'($urandom_range(0, 5));
          else
            yy = int'($urandom_range(0, 479));
          x = 10'(xx);
          y = 10'(yy);
          expq.push_back(model(xx, yy));
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    pc_cells = '0;
    cursor_row = 3'd4;
    cursor_col = 3'd4;
    cursor_valid = 1'b1;
    if (((pulses / TB_BF) % 2) == 0) repeat (TB_BF) pulse_frame();
    settle(600, 390);
    n_cmp++;
    if (rgb !== 24'hFFFF00) begin
      n_bad++;
      $display("FAIL midrun_cursor_lit: got %06h expected FFFF00", rgb);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (rgb !== 24'h000000) begin
      n_bad++;
      $display("FAIL midrun_async_clear: got %06h expected 000000", rgb);
    end
    pulse_frame();
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 1; k <= TB_BF; k++) begin
      pulse_frame();
      settle(600, 390);
      n_cmp++;
      if (rgb !== model(600, 390) || rgb !== ((k == TB_BF) ? 24'hFFFF00 : 24'h000060)) begin
        n_bad++;
        $display("FAIL midrun_after_%0d_pulses: got %06h expected %06h", k, rgb,
                 (k == TB_BF) ? 24'hFFFF00 : 24'h000060);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    pulses = 0;
    rst = 1'b1;
    frame_start = 1'b0;
    x = '0;
    y = '0;
    player_cells = '0;
    pc_cells = '0;
    cursor_row = '0;
    cursor_col = '0;
    cursor_valid = 1'b0;
    test_reset();
    test_player_cell();
    test_conceal();
    test_blink();
    test_boundaries();
    test_random_stream();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/battleship_board_render.md
# battleship_board_render

Parametrised, pipelined pixel renderer for the Battleship VGA display. Draws two N×N boards: the player board on the left and the PC board on the right. Each board gets a grid outline and per-cell colours decoded from the game-state arrays. A blinking cursor marks the PC board cell currently being targeted. It sits between the VGA timing generator (which supplies x, y and a per-frame pulse) and the DAC pins, and replaces the fixed-line, combinational board drawer.

## Interface
- N, 5: cells per board side (2..8)
- CELL_W, 54: cell width in pixels
- CELL_H, 70: cell height in pixels
- ORG0_X, 25: player board left edge x
- ORG1_X, 345: PC board left edge x
- ORG_Y, 50: top edge y for both boards
- BLINK_FRAMES, 30: frames per cursor blink half-period (≥1)

- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- x  in  10  current pixel column
- y  in  10  current pixel row
- frame_start  in  1  one-cycle pulse per frame
- player_cells  in  2*N*N  cell codes, cell (r,c) at [2*(r*N+c)+:2]
- pc_cells  in  2*N*N  same layout for the PC board
- cursor_row  in  $clog2(N)  cursor row on the PC board
- cursor_col  in  $clog2(N)  cursor column on the PC board
- cursor_valid  in  1  cursor enable
- r, g, b  out  8 each  registered pixel colour

## Operation
- Cell codes: 0 = water, 1 = ship, 2 = hit, 3 = miss.
- Board extent: x in [ORGk_X, ORGk_X+N*CELL_W], y in [ORG_Y, ORG_Y+N*CELL_H], inclusive.
- Grid line pixel: a pixel inside the board extent where any of these hold:
  - x == ORGk_X + i*CELL_W, for i = 0..N
  - y == ORG_Y + j*CELL_H, for j = 0..N
- Cell index for interior pixels:
  - col = (x − ORGk_X) / CELL_W
  - row = (y − ORG_Y) / CELL_H
  - Unsigned floor division, computed without a divider (comparison chain over N).
- Colour priority, highest first:
  1. Outside both board extents: 000000.
  2. Grid line pixel: FFFFFF.
  3. Cursor fill: PC board cell equal to (cursor_row, cursor_col), cursor_valid=1, blink phase=1 → FFFF00.
  4. Cell code colour:
     - hit → FF0000
     - miss → 808080
     - ship on player board → 00A000
     - ship on PC board → water colour (concealed)
     - water → 000060
- A cursor_row or cursor_col ≥ N draws no cursor.
- Blink unit:
  - Counter counts frame_start pulses from 0 to BLINK_FRAMES−1.
  - When the counter wraps, the blink phase toggles.
  - frame_start pulses that arrive while rst=1 are ignored.

## Timing
- Pipeline stage 1 registers:
  - board select (none / 0 / 1)
  - line flag
  - row and col
- Stage 2:
  - Samples the cell arrays and cursor inputs in that cycle.
  - Registers r, g, b.
- Latency: the colour for (x, y) presented at edge t appears on r, g, b after edge t+2. Throughput is one pixel per clock.
- Reset values:
  - r, g, b = 00
  - all pipeline registers cleared (board select = none)
  - blink counter = 0, blink phase = 0
- Output is black during the first two clocks after reset release.
- Asserting rst mid-frame forces outputs to 00 immediately (asynchronous) and restarts the blink unit at phase 0.
- Cell-array or cursor changes take effect for pixels reaching stage 2 after the change. No frame-level latching is performed.
- frame_start is not pipelined and only drives the blink unit.

## Configuration
- BOARD_PC_REVEAL_EN defined: PC board ship cells render as 00A000 (debug and demo).
- Undefined: PC board ship cells render as water colour 000060. All other behaviour is identical.

## Test plan
All scenarios use default parameters.
- Reset: hold rst=1 with x=25, y=100 → rgb=000000 throughout. Release → FFFFFF two clocks after x=25, y=100 is applied.
- Player board cell: x=30, y=60, player_cells[1:0]=1 → 00A000 two clocks later. Set the code to 2 → FF0000. Set it to 3 → 808080.
- Concealment: x=350, y=60, pc_cells[1:0]=1 → 000060 without BOARD_PC_REVEAL_EN, and 00A000 with it.
- Cursor blink: BLINK_FRAMES=2, cursor (4,4) valid, x=600, y=390:
  - 000060 after reset
  - FFFF00 after 2 frame_start pulses
  - 000060 after 4 pulses
  - setting cursor_valid=0 while in phase 1 → 000060
- Boundaries:
  - x=10, y=10 → 000000
  - x=320, y=200 (gap between boards) → 000000
  - x=615, y=400 → FFFFFF
  - x=616, y=400 → 000000
- Reset mid-run: assert rst while the cursor shows FFFF00 → rgb=000000 within the same cycle. After release, the cursor stays dark until BLINK_FRAMES pulses have been received.
